// File: rtl/mult_seq_nxn.sv
// Sequential radix-2 shift-and-add NxN multiplier with start/done handshake.
// Operands are captured on start; signed mode multiplies magnitudes and fixes the sign at the end.
module mult_seq_nxn #(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   mplier,
  input  logic [N-1:0]   mcand,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [W2-1:0] acc_q, acc_d;
  logic [W2-1:0] product_q, product_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          last_c;
  logic [W2-1:0] addend_c;

  // The most negative value maps to 2^(N-1), which still fits in N unsigned bits.
  function automatic logic [N-1:0] mag_f(input logic sgn, input logic [N-1:0] v);
    return (sgn && v[N-1]) ? (~v + N'(1)) : v;
  endfunction

  assign last_c   = (cnt_q == CW'(N - 1));
  assign addend_c = {{N{1'b0}}, mcand_q} << cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_SIGN;
      S_SIGN:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mplier_d = mag_f(is_signed, mplier);
          mcand_d  = mag_f(is_signed, mcand);
          neg_d    = is_signed & (mplier[N-1] ^ mcand[N-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + addend_c;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
      S_SIGN: begin
        // Product is published on the edge that enters DONE.
        acc_d     = neg_q ? (~acc_q + W2'(1)) : acc_q;
        product_d = acc_d;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mplier_q  <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
